axi4_stream_pkt_sched: RTL and testbench
========================================

AXI4_STREAM_PKT_SCHED -- requirements
Module: axi4_stream_pkt_sched

Purpose: packet-granular round-robin scheduler that shares one downstream AXI4-Stream packet splitter among N_SRC sources. It selects the per-source maximum packet size and holds it stable for the whole packet.

Interface
REQ-001 SHALL have parameters: N_SRC, default 4, number of sources (2..16).
REQ-002 SHALL have parameters: DATA_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH, defaults 32/1/1/1, stream field widths.
REQ-003 SHALL have parameters: MAX_PKT_SIZE_B, default 2048; PKT_SIZE_WIDTH, default $clog2(MAX_PKT_SIZE_B).
REQ-004 SHALL have ports, as name  direction  width  meaning:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- src_en_i  in  N_SRC  per-source enable mask.
- max_pkt_size_i  in  N_SRC x (PKT_SIZE_WIDTH+1)  per-source max packet size, bytes.
- max_pkt_size_o  out  PKT_SIZE_WIDTH+1  size for the granted source, to the splitter.
- grant_o  out  $clog2(N_SRC)  index of the granted source.
- busy_o  out  1  a packet is in progress.
- pkt_i[N_SRC]  axi4_stream_if slave array  source streams.
- pkt_o  axi4_stream_if master  to the splitter input.

Function
REQ-005 SHALL implement the states IDLE_S, ARB_S and PKT_S.
REQ-006 IDLE_S SHALL move to ARB_S when any source k has pkt_i[k].tvalid && src_en_i[k].
REQ-007 ARB_S SHALL pick the winner as the first requesting enabled source, searching from last_grant+1 modulo N_SRC upward.
REQ-008 ARB_S SHALL register the winner into grant, capture max_pkt_size_i[winner] into max_pkt_size_o, and go to PKT_S, all in one cycle.
REQ-009 ARB_S SHALL return to IDLE_S with no grant change if the request has been withdrawn in the ARB_S cycle.
REQ-010 PKT_S SHALL connect pkt_o to pkt_i[grant] combinationally: tdata, tvalid, tlast, tkeep, tstrb, tid, tdest and tuser, and route pkt_i[grant].tready = pkt_o.tready.
REQ-011 Every non-granted source SHALL see tready = 0 in every state; in IDLE_S and ARB_S all tready SHALL be 0 and pkt_o.tvalid SHALL be 0.
REQ-012 PKT_S SHALL go to IDLE_S on the cycle where pkt_i[grant].tvalid && pkt_o.tready && pkt_i[grant].tlast, and SHALL update last_grant <= grant on that cycle.
REQ-013 Arbitration overhead SHALL be exactly 2 cycles between the tlast beat and the first beat of the next packet (IDLE_S, ARB_S).
REQ-014 Maximum throughput SHALL be L/(L+2) beats per cycle for L-beat packets.
REQ-015 max_pkt_size_o SHALL hold constant from ARB_S until the next ARB_S, whatever max_pkt_size_i does meanwhile.
REQ-016 Deasserting src_en_i[grant] during PKT_S SHALL NOT abort the packet; the block SHALL only exclude that source from later arbitration.
REQ-017 A 1-beat packet (tvalid && tlast on the first PKT_S cycle) SHALL be handled as in REQ-012.
REQ-018 Backpressure: while pkt_o.tready = 0 the block SHALL stay in PKT_S and hold grant; the AXI rule "tvalid never depends on tready" SHALL hold on pkt_o.
REQ-019 busy_o SHALL be 1 in ARB_S and PKT_S, 0 in IDLE_S.
REQ-020 grant_o SHALL always reflect the registered grant.
REQ-021 When all src_en_i are 0, the block SHALL stay in IDLE_S indefinitely.

Reset
REQ-022 On rst_i the block SHALL enter IDLE_S with grant = 0 and last_grant = N_SRC-1, so source 0 has first priority.
REQ-023 On rst_i max_pkt_size_o SHALL be 0, busy_o SHALL be 0, pkt_o.tvalid SHALL be 0 and all pkt_i tready SHALL be 0.
REQ-024 Reset asserted mid-packet SHALL abandon the packet immediately; the bench must also reset the sources and the splitter.

Verification
REQ-025 Reset: rst_i pulse -> busy_o=0, grant_o=0, max_pkt_size_o=0, all tready=0.
REQ-026 Fairness: N_SRC=4, all sources continuously sending 3-beat packets, max_pkt_size_i = {64,128,256,512} -> grant order 0,1,2,3,0,…; max_pkt_size_o equals the granted source's size each packet; 2 idle cycles between packets.
REQ-027 Atomicity: source 2 is mid-packet and pkt_o.tready is toggled randomly -> no beats from any other source appear on pkt_o until source 2's tlast; data is byte-exact.
REQ-028 Config hold: max_pkt_size_i[1] changes from 100 to 40 during source 1's packet -> max_pkt_size_o stays 100 until the next ARB_S.
REQ-029 Enable mask: src_en_i=4'b1010, all sources valid -> only sources 1 and 3 are granted, alternating; disabling source 1 mid-packet completes that packet, then only source 3 is granted.
REQ-030 Single-beat packets: sources 0 and 3 each send 1-beat packets -> alternating grants, 3 cycles per packet.

Source files
------------

// File: rtl/axi4_stream_pkt_sched_if.sv
// AXI4-Stream bundle shared by the packet sources and the downstream splitter.
// The master drives payload/sideband and tvalid; the slave drives tready.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (output tdata, tvalid, tlast, tkeep, tstrb, tid, tdest, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tkeep, tstrb, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axi4_stream_pkt_sched.sv
// Packet-granular round-robin scheduler: one source owns the splitter for a whole
// packet, and its max packet size is latched at arbitration and held until the next one.
module axi4_stream_pkt_sched #(
  parameter int N_SRC          = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 1,
  parameter int DEST_WIDTH     = 1,
  parameter int USER_WIDTH     = 1,
  parameter int MAX_PKT_SIZE_B = 2048,
  parameter int PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [N_SRC-1:0]                      src_en_i,
  input  logic [N_SRC-1:0][PKT_SIZE_WIDTH:0]    max_pkt_size_i,
  output logic [PKT_SIZE_WIDTH:0]               max_pkt_size_o,
  output logic [$clog2(N_SRC)-1:0]              grant_o,
  output logic                                  busy_o,
  axi4_stream_if.slave                          pkt_i [N_SRC],
  axi4_stream_if.master                         pkt_o
);
  localparam int GW = $clog2(N_SRC);
  localparam int KW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE_S, ARB_S, PKT_S} state_t;

  state_t                  state_reg;
  logic [GW-1:0]           grant_reg;
  logic [GW-1:0]           last_grant_reg;
  logic [PKT_SIZE_WIDTH:0] max_pkt_size_reg;
  logic                    busy_reg;

  logic [N_SRC-1:0]        src_tvalid;
  logic [N_SRC-1:0]        src_tlast;
  logic [N_SRC-1:0]        src_tready;
  logic [DATA_WIDTH-1:0]   src_tdata [N_SRC];
  logic [KW-1:0]           src_tkeep [N_SRC];
  logic [KW-1:0]           src_tstrb [N_SRC];
  logic [ID_WIDTH-1:0]     src_tid   [N_SRC];
  logic [DEST_WIDTH-1:0]   src_tdest [N_SRC];
  logic [USER_WIDTH-1:0]   src_tuser [N_SRC];

  logic [N_SRC-1:0]        req;
  logic [GW:0]             scan_sum;
  logic [GW-1:0]           winner_next;
  logic                    pkt_active;
  logic                    pkt_end;

  // Interface arrays cannot be indexed by a run-time value, so flatten them first.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    assign src_tvalid[gi] = pkt_i[gi].tvalid;
    assign src_tlast[gi]  = pkt_i[gi].tlast;
    assign src_tdata[gi]  = pkt_i[gi].tdata;
    assign src_tkeep[gi]  = pkt_i[gi].tkeep;
    assign src_tstrb[gi]  = pkt_i[gi].tstrb;
    assign src_tid[gi]    = pkt_i[gi].tid;
    assign src_tdest[gi]  = pkt_i[gi].tdest;
    assign src_tuser[gi]  = pkt_i[gi].tuser;
    assign src_tready[gi] = pkt_active && (grant_reg == GW'(gi)) && pkt_o.tready;
    assign pkt_i[gi].tready = src_tready[gi];
  end

  assign req        = src_tvalid & src_en_i;
  assign pkt_active = (state_reg == PKT_S);

  // Scan downward so the last hit is the nearest source after last_grant.
  always_comb begin
    winner_next = grant_reg;
    scan_sum    = '0;
    for (int i = N_SRC; i >= 1; i--) begin
      scan_sum = {1'b0, last_grant_reg} + (GW+1)'(i);
      if (scan_sum >= (GW+1)'(N_SRC))
        scan_sum = scan_sum - (GW+1)'(N_SRC);
      if (req[scan_sum[GW-1:0]])
        winner_next = scan_sum[GW-1:0];
    end
  end

  assign pkt_o.tvalid = pkt_active && src_tvalid[grant_reg];
  assign pkt_o.tdata  = src_tdata[grant_reg];
  assign pkt_o.tlast  = src_tlast[grant_reg];
  assign pkt_o.tkeep  = src_tkeep[grant_reg];
  assign pkt_o.tstrb  = src_tstrb[grant_reg];
  assign pkt_o.tid    = src_tid[grant_reg];
  assign pkt_o.tdest  = src_tdest[grant_reg];
  assign pkt_o.tuser  = src_tuser[grant_reg];

  assign pkt_end = pkt_o.tvalid && pkt_o.tready && src_tlast[grant_reg];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg        <= IDLE_S;
      grant_reg        <= '0;
      last_grant_reg   <= GW'(N_SRC - 1);
      max_pkt_size_reg <= '0;
      busy_reg         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE_S: begin
          if (|req) begin
            state_reg <= ARB_S;
            busy_reg  <= 1'b1;
          end
        end
        ARB_S: begin
          // A request withdrawn during arbitration leaves grant and size untouched.
          if (|req) begin
            grant_reg        <= winner_next;
            max_pkt_size_reg <= max_pkt_size_i[winner_next];
            state_reg        <= PKT_S;
          end else begin
            state_reg <= IDLE_S;
            busy_reg  <= 1'b0;
          end
        end
        PKT_S: begin
          if (pkt_end) begin
            last_grant_reg <= grant_reg;
            state_reg      <= IDLE_S;
            busy_reg       <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE_S;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign max_pkt_size_o = max_pkt_size_reg;
  assign grant_o        = grant_reg;
  assign busy_o         = busy_reg;
endmodule

// File: tb/tb_axi4_stream_pkt_sched.sv
// Directed bench for the packet scheduler: a vector table for arbitration order and
// latency, plus hand-written multi-cycle sequences with a beat-level monitor.
module tb_axi4_stream_pkt_sched;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int PSW = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]         en;
  logic [N-1:0][PSW:0]  sizes;
  logic [PSW:0]         max_o;
  logic [1:0]           grant;
  logic                 busy;
  logic                 dst_ready;
  logic [N-1:0]         s_valid, s_last, s_ready, s_on;
  logic [DW-1:0]        s_data [N];
  int                   s_len [N];
  int                   s_cnt [N];
  int                   s_pkt [N];

  axi4_stream_if #(.DATA_WIDTH(DW)) src_if [N] ();
  axi4_stream_if #(.DATA_WIDTH(DW)) dst_if ();

  for (genvar gi = 0; gi < N; gi++) begin : g_src
    assign src_if[gi].tvalid = s_valid[gi];
    assign src_if[gi].tdata  = s_data[gi];
    assign src_if[gi].tlast  = s_last[gi];
    assign src_if[gi].tkeep  = 4'hF;
    assign src_if[gi].tstrb  = 4'hF;
    assign src_if[gi].tid    = 1'(gi);
    assign src_if[gi].tdest  = 1'b0;
    assign src_if[gi].tuser  = 1'b0;
    assign s_ready[gi]       = src_if[gi].tready;
  end
  assign dst_if.tready = dst_ready;

  axi4_stream_pkt_sched #(.N_SRC(N), .DATA_WIDTH(DW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .src_en_i       (en),
    .max_pkt_size_i (sizes),
    .max_pkt_size_o (max_o),
    .grant_o        (grant),
    .busy_o         (busy),
    .pkt_i          (src_if),
    .pkt_o          (dst_if)
  );

  int checks = 0;
  int failures = 0;

  // Monitor state: current packet owner, packet starts, and gaps between packets.
  int           cur_src, cyc, last_end;
  logic [PSW:0] pkt_sz;
  int           gq[$];
  int           szq[$];
  int           gapq[$];
  logic         prev_stall;
  logic [DW-1:0] prev_data;
  logic [N-1:0] hs;

  typedef struct {
    logic [3:0] en;
    logic [3:0] req;
    int         exp_grant;
    int         exp_size;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_clear();
    cur_src = -1;
    last_end = -1;
    prev_stall = 1'b0;
    gq.delete();
    szq.delete();
    gapq.delete();
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      s_valid[k] = s_on[k];
      s_data[k]  = {8'(k), 8'(s_pkt[k]), 16'(s_cnt[k])};
      s_last[k]  = (s_cnt[k] == s_len[k] - 1);
    end
  endtask

  task automatic sample();
    int src;
    logic [DW-1:0] exp_data;
    hs = s_valid & s_ready;
    if (!busy) chk("idle_quiet", {dst_if.tvalid, s_ready}, 0);
    else       chk("ready_iso", s_ready & ~(4'b0001 << grant), 0);
    if (prev_stall) begin
      chk("tvalid_hold", dst_if.tvalid, 1);
      chk("tdata_hold", dst_if.tdata, prev_data);
    end
    prev_stall = dst_if.tvalid && !dst_ready;
    prev_data  = dst_if.tdata;
    if (dst_if.tvalid && dst_ready) begin
      src = int'(dst_if.tdata[31:24]);
      if (src >= N) begin
        chk("src_range", src, 0);
        src = 0;
      end
      if (cur_src < 0) begin
        gq.push_back(src);
        szq.push_back(int'(max_o));
        if (last_end >= 0) gapq.push_back(cyc - last_end);
        cur_src = src;
        pkt_sz  = sizes[src];
        chk("grant_src", grant, src);
      end
      chk("atomic_src", src, cur_src);
      chk("size_out", max_o, pkt_sz);
      exp_data = {8'(cur_src), 8'(s_pkt[cur_src]), 16'(s_cnt[cur_src])};
      chk("beat_data", dst_if.tdata, exp_data);
      chk("beat_last", dst_if.tlast, s_last[cur_src]);
      chk("beat_side", {dst_if.tkeep, dst_if.tstrb, dst_if.tid}, {4'hF, 4'hF, 1'(cur_src)});
      chk("src_hs", hs, 4'b0001 << cur_src);
      if (dst_if.tlast) begin
        cur_src  = -1;
        last_end = cyc;
      end
    end else begin
      chk("no_stray_hs", hs, 0);
    end
  endtask

  task automatic cycle();
    drive();
    #1;
    sample();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (hs[k]) begin
        if (s_last[k]) begin
          s_cnt[k] = 0;
          s_pkt[k] = s_pkt[k] + 1;
        end else begin
          s_cnt[k] = s_cnt[k] + 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic rst_checks();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_size", max_o, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_tvalid", dst_if.tvalid, 0);
  endtask

  // Asserted at a falling edge so the first check sees the asynchronous response.
  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      s_cnt[k] = 0;
      s_pkt[k] = 0;
    end
    drive();
    #1;
    rst_checks();
    @(negedge clk);
    drive();
    #1;
    rst_checks();
    @(negedge clk);
    rst = 1'b0;
    mon_clear();
  endtask

  initial begin
    int n, start, cnt2;
    int exp_e [8];
    tbl[0]  = '{4'b1111, 4'b1111, 0, 64};
    tbl[1]  = '{4'b1111, 4'b1111, 1, 128};
    tbl[2]  = '{4'b1111, 4'b0101, 2, 256};
    tbl[3]  = '{4'b1111, 4'b0101, 0, 64};
    tbl[4]  = '{4'b1010, 4'b1111, 1, 128};
    tbl[5]  = '{4'b1010, 4'b1111, 3, 512};
    tbl[6]  = '{4'b1111, 4'b1000, 3, 512};
    tbl[7]  = '{4'b0001, 4'b1111, 0, 64};
    tbl[8]  = '{4'b1111, 4'b0110, 1, 128};
    tbl[9]  = '{4'b1111, 4'b0110, 2, 256};
    tbl[10] = '{4'b1111, 4'b0010, 1, 128};
    exp_e = '{1, 3, 1, 3, 1, 3, 3, 3};

    sizes[0] = 12'd64;  sizes[1] = 12'd128;
    sizes[2] = 12'd256; sizes[3] = 12'd512;
    en = 4'hF; s_on = 4'hF; dst_ready = 1'b1; rst = 1'b0; cyc = 0;
    for (int k = 0; k < N; k++) s_len[k] = 1;
    mon_clear();
    @(negedge clk);
    do_reset();

    // Arbitration table: 1-beat packets, each record must win in exactly 3 cycles.
    for (int v = 0; v < 11; v++) begin
      en = tbl[v].en;
      s_on = tbl[v].req;
      start = gq.size();
      n = 0;
      while (gq.size() == start && n < 12) begin
        cycle();
        n++;
      end
      chk("tbl_latency", n, 3);
      if (gq.size() > start) begin
        chk("tbl_grant", gq[gq.size()-1], tbl[v].exp_grant);
        chk("tbl_size", szq[szq.size()-1], tbl[v].exp_size);
      end
    end
    s_on = 4'h0;
    cycle();
    cycle();
    do_reset();

    // Fairness: 3-beat packets from every source, two dead cycles between packets.
    en = 4'hF; s_on = 4'hF;
    for (int k = 0; k < N; k++) s_len[k] = 3;
    n = 0;
    while (gq.size() < 9 && n < 200) begin
      cycle();
      n++;
    end
    chk("fair_count", gq.size() >= 9, 1);
    for (int i = 0; i < 8 && i < gq.size(); i++) chk("fair_order", gq[i], i % 4);
    chk("fair_gap_count", gapq.size() >= 8, 1);
    foreach (gapq[i]) chk("fair_gap", gapq[i], 3);
    // Ninth packet is mid-flight here: reset abandons it.
    do_reset();

    // Atomicity under random backpressure with mixed packet lengths.
    s_len = '{2, 3, 5, 4};
    for (int i = 0; i < 300; i++) begin
      dst_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    dst_ready = 1'b1;
    chk("atom_pkts", gq.size() >= 10, 1);
    if (gq.size() > 0) chk("atom_first_grant", gq[0], 0);
    cnt2 = 0;
    foreach (gq[i]) if (gq[i] == 2) cnt2++;
    chk("atom_src2_seen", cnt2 >= 2, 1);
    do_reset();

    // Config hold: size changes mid-packet, takes effect only at the next arbitration.
    sizes[1] = 12'd100;
    s_on = 4'b0010;
    s_len[1] = 4;
    n = 0;
    while (gq.size() < 1 && n < 20) begin
      cycle();
      n++;
    end
    sizes[1] = 12'd40;
    cycle();
    chk("hold_mid", max_o, 100);
    n = 0;
    while (gq.size() < 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("hold_pkts", gq.size(), 2);
    if (gq.size() >= 2) begin
      chk("hold_first", szq[0], 100);
      chk("hold_second", szq[1], 40);
    end
    sizes[1] = 12'd128;
    do_reset();

    // Enable mask, then disable source 1 in the middle of its packet.
    en = 4'b1010; s_on = 4'hF;
    for (int k = 0; k < N; k++) s_len[k] = 3;
    n = 0;
    while (!(gq.size() >= 5 && cur_src == 1) && n < 200) begin
      cycle();
      n++;
    end
    en = 4'b1000;
    n = 0;
    while (gq.size() < 8 && n < 200) begin
      cycle();
      n++;
    end
    chk("mask_count", gq.size() >= 8, 1);
    for (int i = 0; i < 8 && i < gq.size(); i++) chk("mask_order", gq[i], exp_e[i]);
    do_reset();

    // Single-beat packets from sources 0 and 3.
    en = 4'hF; s_on = 4'b1001;
    for (int k = 0; k < N; k++) s_len[k] = 1;
    n = 0;
    while (gq.size() < 6 && n < 100) begin
      cycle();
      n++;
    end
    chk("single_count", gq.size() >= 6, 1);
    for (int i = 0; i < 6 && i < gq.size(); i++) chk("single_order", gq[i], (i % 2) * 3);
    foreach (gapq[i]) chk("single_gap", gapq[i], 3);
    do_reset();

    // Everything disabled: the block must never leave idle.
    en = 4'h0; s_on = 4'hF;
    for (int i = 0; i < 20; i++) cycle();
    chk("off_pkts", gq.size(), 0);
    chk("off_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
